// File: rtl/rs_issue_picker_pkg.sv
// rs_issue_picker_pkg
//   Shared constants and types for the reservation-station issue picker.
//   RS_SIZE_DEF / RS_BIT_DEF : default slot count and slot index width.
//   RS_NONE                  : index reported when no slot applies (e.g. alloc while full).
//   occ_op_e                 : per-cycle occupancy counter operation.
package rs_issue_picker_pkg;

    localparam int RS_SIZE_DEF = 16;
    localparam int RS_BIT_DEF  = 4;

    localparam logic [RS_BIT_DEF-1:0] RS_NONE = '0;

    typedef enum logic [1:0] {
        OCC_HOLD = 2'd0,
        OCC_INC  = 2'd1,
        OCC_DEC  = 2'd2,
        OCC_CLR  = 2'd3
    } occ_op_e;

endpackage

// File: rtl/rs_issue_picker_age.sv
// rs_age_matrix
//   Allocation-age tracker used only when RS_OLDEST_FIRST_EN is defined.
//   older[j][i] = 1 means slot j was allocated before slot i.
//   Ports:
//     clk_in, rst_in   clock, asynchronous active-high reset
//     flush            clear all age state (already qualified with the global enable)
//     alloc_onehot     one-hot of the slot allocated this cycle, zero when no alloc fires
//     busy             slot occupancy from the RS entry array
//     eligible         slots that may be picked this cycle
//     oldest_onehot    the single eligible slot that no other eligible slot is older than
module rs_age_matrix #(
    parameter int RS_SIZE = 16
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               flush,
    input  logic [RS_SIZE-1:0] alloc_onehot,
    input  logic [RS_SIZE-1:0] busy,
    input  logic [RS_SIZE-1:0] eligible,
    output logic [RS_SIZE-1:0] oldest_onehot
);

    logic [RS_SIZE-1:0] older [RS_SIZE];

    // A newly allocated slot is younger than everything currently busy and older
    // than nothing. Stale bits left by freed slots are harmless: a freed slot is
    // never eligible, and its row is wiped when it is allocated again.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int j = 0; j < RS_SIZE; j++)
                older[j] <= '0;
        end else if (flush) begin
            for (int j = 0; j < RS_SIZE; j++)
                older[j] <= '0;
        end else if (|alloc_onehot) begin
            for (int j = 0; j < RS_SIZE; j++) begin
                if (alloc_onehot[j]) begin
                    older[j] <= '0;
                end else begin
                    for (int i = 0; i < RS_SIZE; i++)
                        if (alloc_onehot[i])
                            older[j][i] <= busy[j];
                end
            end
        end
    end

    always_comb begin
        oldest_onehot = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            logic blocked;
            blocked = 1'b0;
            for (int j = 0; j < RS_SIZE; j++)
                if (eligible[j] && older[j][i])
                    blocked = 1'b1;
            oldest_onehot[i] = eligible[i] & ~blocked;
        end
    end

endmodule

// File: rtl/rs_issue_picker.sv
// rs_issue_picker
//   Registered allocate/issue selector for the reservation station. Reports the
//   lowest free slot for dispatch and picks one prepared slot for the ALU, holding
//   the pick in an output register under a valid/ready handshake.
//   Build option: define RS_OLDEST_FIRST_EN to pick the oldest eligible slot
//   (age matrix); otherwise the lowest-index eligible slot is picked.
//   Ports:
//     clk_in       clock
//     rst_in       asynchronous active-high reset
//     rdy_in       global enable; 0 freezes all state
//     clear_in     flush: drop issue register, occupancy and age state
//     busy         slot occupied
//     prepared     slot busy with all operands ready
//     alloc_valid  dispatch requests a slot
//     full         no free slot (comb.)
//     alloc_entry  lowest free slot, 0 when full (comb.)
//     issue_valid  issue_entry holds a slot to execute (reg.)
//     issue_ready  ALU accepts issue_entry
//     issue_entry  slot being issued (reg.)
//     occupancy    slots allocated and not yet issued (reg.)
module rs_issue_picker
    import rs_issue_picker_pkg::*;
#(
    parameter int RS_SIZE = RS_SIZE_DEF,
    parameter int RS_BIT  = RS_BIT_DEF
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               clear_in,
    input  logic [RS_SIZE-1:0] busy,
    input  logic [RS_SIZE-1:0] prepared,
    input  logic               alloc_valid,
    output logic               full,
    output logic [RS_BIT-1:0]  alloc_entry,
    output logic               issue_valid,
    input  logic               issue_ready,
    output logic [RS_BIT-1:0]  issue_entry,
    output logic [RS_BIT:0]    occupancy
);

    localparam logic [RS_BIT:0] OCC_MAX = (RS_BIT+1)'(RS_SIZE);

    logic               alloc_fire;
    logic               issue_fire;
    logic               issue_load;
    logic               flush;
    logic [RS_SIZE-1:0] held_mask;
    logic [RS_SIZE-1:0] eligible;
    logic               pick_valid;
    logic [RS_BIT-1:0]  pick_entry;
    occ_op_e            occ_op;

    // ---------------- allocation ----------------
    assign full = &busy;

    always_comb begin
        alloc_entry = RS_BIT'(RS_NONE);
        for (int i = RS_SIZE - 1; i >= 0; i--)
            if (!busy[i])
                alloc_entry = RS_BIT'(i);
    end

    assign flush      = rdy_in & clear_in;
    assign alloc_fire = rdy_in & ~clear_in & alloc_valid & ~full;
    assign issue_fire = rdy_in & issue_valid & issue_ready;
    assign issue_load = rdy_in & (~issue_valid | issue_ready);

    // The slot sitting in the issue register is still prepared until the RS sees
    // the fire, so it must be masked out or it would be issued twice.
    assign held_mask = issue_valid ? (RS_SIZE'(1) << issue_entry) : '0;
    assign eligible  = prepared & ~held_mask;
    assign pick_valid = |eligible;

    // ---------------- pick ----------------
`ifdef RS_OLDEST_FIRST_EN
    logic [RS_SIZE-1:0] alloc_onehot;
    logic [RS_SIZE-1:0] oldest_onehot;

    assign alloc_onehot = alloc_fire ? (RS_SIZE'(1) << alloc_entry) : '0;

    rs_age_matrix #(
        .RS_SIZE (RS_SIZE)
    ) u_age (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .flush         (flush),
        .alloc_onehot  (alloc_onehot),
        .busy          (busy),
        .eligible      (eligible),
        .oldest_onehot (oldest_onehot)
    );

    always_comb begin
        pick_entry = '0;
        for (int i = 0; i < RS_SIZE; i++)
            if (oldest_onehot[i])
                pick_entry = pick_entry | RS_BIT'(i);
    end
`else
    always_comb begin
        pick_entry = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--)
            if (eligible[i])
                pick_entry = RS_BIT'(i);
    end
`endif

    // ---------------- issue register ----------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            issue_valid <= 1'b0;
            issue_entry <= '0;
        end else if (flush) begin
            issue_valid <= 1'b0;
        end else if (issue_load) begin
            issue_valid <= pick_valid;
            if (pick_valid)
                issue_entry <= pick_entry;
        end
    end

    // ---------------- occupancy ----------------
    always_comb begin
        occ_op = OCC_HOLD;
        if (flush)
            occ_op = OCC_CLR;
        else if (alloc_fire && !issue_fire)
            occ_op = OCC_INC;
        else if (issue_fire && !alloc_fire)
            occ_op = OCC_DEC;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            occupancy <= '0;
        end else begin
            case (occ_op)
                OCC_CLR:  occupancy <= '0;
                OCC_INC:  if (occupancy != OCC_MAX) occupancy <= occupancy + 1'b1;
                OCC_DEC:  if (occupancy != '0)      occupancy <= occupancy - 1'b1;
                default:  occupancy <= occupancy;
            endcase
        end
    end

    // Saturation means the RS and this counter disagree about slot ownership.
    assert property (@(posedge clk_in) disable iff (rst_in)
        !(occ_op == OCC_INC && occupancy == OCC_MAX));
    assert property (@(posedge clk_in) disable iff (rst_in)
        !(occ_op == OCC_DEC && occupancy == '0));

endmodule
